ysyx_23060240_mem_arbiter: RTL and testbench
============================================

# ysyx_23060240_mem_arbiter

Shares the single data-memory port between the IFU (read-only fetch) and the LSU (load/store), ahead of the SRAM-backed memory model. It serialises the two requesters so only one transaction is outstanding at a time. It latches the winning request, drives it to memory with a valid/ready handshake, waits for the memory response and routes it back to the owner. One transaction is in flight at a time; there is no reordering.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.
- `MASK_W`, default 8, write byte-mask width.

Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `ifu_req_valid`  in  1  IFU fetch request
- `ifu_req_ready`  out  1  IFU request accepted this cycle
- `ifu_raddr`  in  ADDR_W  fetch address
- `ifu_resp_valid`  out  1  one-cycle pulse, fetch data valid
- `ifu_rdata`  out  DATA_W  fetch data
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_addr`  in  ADDR_W  load/store address
- `lsu_wdata`  in  DATA_W  store data
- `lsu_wmask`  in  MASK_W  store byte mask
- `lsu_resp_valid`  out  1  one-cycle pulse, load data valid or store acknowledged
- `lsu_rdata`  out  DATA_W  load data
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/ADDR_W/DATA_W/MASK_W  latched request fields
- `mem_resp_valid`  in  1  memory response, for both reads and writes
- `mem_rdata`  in  DATA_W  memory read data

## Operation
- The FSM has three states: IDLE, REQ and WAIT. Reset enters IDLE.
- **IDLE**
  - If any `*_req_valid` is high, the winner's `*_req_ready` goes high combinationally in the same cycle. The loser's ready stays 0.
  - On that handshake, the winner's addr, we, wdata and wmask are latched and the owner is recorded. The FSM moves to REQ.
  - IFU requests latch `we=0`, `wdata=0`, `wmask=0`.
- **REQ**
  - `mem_req_valid=1` with the latched fields. The fields stay stable until `mem_req_ready`.
  - On `mem_req_valid && mem_req_ready`, the FSM moves to WAIT.
- **WAIT**
  - `mem_req_valid=0`.
  - On `mem_resp_valid`, the owner's `*_resp_valid=1` for that cycle and its `*_rdata=mem_rdata`. The FSM moves to IDLE.
- The non-owner's `*_resp_valid` is always 0. Any `*_rdata` is 0 whenever its `*_resp_valid` is 0.
- Requesters accept responses unconditionally; there is no response backpressure.
- `mem_resp_valid` in IDLE or REQ is spurious and is ignored. This includes a late response after reset.
- Arbitration on simultaneous valids is set by the configuration macro (see Configuration).

## Timing
- Reset values:
  - all `*_req_ready`, `*_resp_valid` and `mem_req_valid` are 0
  - `mem_we=0`; `mem_addr`, `mem_wdata` and `mem_wmask` are 0
  - state is IDLE and the owner is LSU
- Cycle N: request accepted in IDLE. Cycle N+1: `mem_req_valid` goes high.
- Fastest round trip: `mem_req_ready` at N+1 and `mem_resp_valid` at N+2 give `*_resp_valid` at N+2 and IDLE at N+3. That allows at most one transaction per 3 cycles.
- Memory must not assert `mem_resp_valid` in the same cycle it accepts a request. If it does, the response is ignored.
- A new request is never accepted in the cycle a response is delivered; the next acceptance is the following cycle.
- Reset asserted mid-transaction:
  - all outputs return to reset values immediately
  - the pending transaction is abandoned and no response is delivered to either requester

## Configuration
- `YSYX_23060240_ARB_RR_EN` defined: round-robin. A 1-bit last-grant register is updated on every accept; its reset value is LSU, so the first tie goes to IFU. On a tie the requester not granted last wins.
- `YSYX_23060240_ARB_RR_EN` undefined: fixed priority. LSU wins every tie and no last-grant register exists.
- A lone requester always wins in both modes.

## Structure
- Package `ysyx_23060240_mem_pkg`:
  - state enum `arb_state_t` (IDLE, REQ, WAIT)
  - owner encoding `arb_owner_t` (OWN_IFU, OWN_LSU)
  - default width constants
- Sub-module `ysyx_23060240_arb_pick`: combinational winner selection from the two valids and last-grant, with the macro applied inside it. FSM and datapath latches stay in the top level.

## Test plan
- Lone IFU read of `0x80000000`, memory ready at once, data `0x00000413` one cycle later -> `ifu_resp_valid` pulses with `0x00000413`, response at N+2, `lsu_resp_valid` stays 0.
- LSU store `addr=0x80001000`, `wdata=0xDEADBEEF`, `wmask=0x0F` -> `mem_we=1` with those fields held stable through 3 cycles of `mem_req_ready=0`, and `lsu_resp_valid` pulses on the ack.
- Both valid continuously for 4 transactions -> fixed priority grants LSU four times; RR grants IFU, LSU, IFU, LSU.
- `mem_resp_valid` pulsed in IDLE and in REQ -> no `*_resp_valid` and no state change.
- `rst` pulsed during WAIT, then memory responds -> all outputs 0, no response delivered, and the next IFU request completes normally.

Source files
------------

// File: rtl/ysyx_23060240_mem_pkg.sv
// Shared types and default widths for the IFU/LSU data-memory arbiter.
package ysyx_23060240_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MASK_W_DEF = 8;

endpackage

// File: rtl/ysyx_23060240_arb_pick.sv
// Combinational winner selection between IFU and LSU requests.
// YSYX_23060240_ARB_RR_EN selects round-robin ties; otherwise LSU has fixed priority.
module ysyx_23060240_arb_pick
  import ysyx_23060240_mem_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef YSYX_23060240_ARB_RR_EN
  input  arb_owner_t last_grant,
`endif
  output logic       grant_ifu,
  output logic       grant_lsu
);

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
`ifdef YSYX_23060240_ARB_RR_EN
    // On a tie the requester that was not granted last goes first.
    grant_ifu = ifu_valid && (!lsu_valid || (last_grant == OWN_LSU));
    grant_lsu = lsu_valid && !grant_ifu;
`else
    grant_lsu = lsu_valid;
    grant_ifu = ifu_valid && !lsu_valid;
`endif
  end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port, one transaction in flight.
// Tie-break policy chosen by YSYX_23060240_ARB_RR_EN (round-robin) or fixed LSU priority.
module ysyx_23060240_mem_arbiter
  import ysyx_23060240_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_raddr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  arb_owner_t owner;
  logic       pick_ifu;
  logic       pick_lsu;
  logic       idle_open;
  logic       deliver;

`ifdef YSYX_23060240_ARB_RR_EN
  arb_owner_t last_grant;
`endif

  ysyx_23060240_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
`ifdef YSYX_23060240_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant_ifu  (pick_ifu),
    .grant_lsu  (pick_lsu)
  );

  // Readies are masked while rst is held so no requester sees an acceptance that is never latched.
  assign idle_open     = (state == IDLE) && !rst;
  assign ifu_req_ready = idle_open && pick_ifu;
  assign lsu_req_ready = idle_open && pick_lsu;

  assign deliver        = (state == WAIT) && mem_resp_valid;
  assign ifu_resp_valid = deliver && (owner == OWN_IFU);
  assign lsu_resp_valid = deliver && (owner == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_LSU;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
`ifdef YSYX_23060240_ARB_RR_EN
      last_grant    <= OWN_LSU;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ifu_req_ready) begin
            owner         <= OWN_IFU;
            mem_we        <= 1'b0;
            mem_addr      <= ifu_raddr;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_23060240_ARB_RR_EN
            last_grant    <= OWN_IFU;
`endif
          end else if (lsu_req_ready) begin
            owner         <= OWN_LSU;
            mem_we        <= lsu_we;
            mem_addr      <= lsu_addr;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef YSYX_23060240_ARB_RR_EN
            last_grant    <= OWN_LSU;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) state <= IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model.
module tb_ysyx_23060240_mem_arbiter;

`ifdef YSYX_23060240_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_raddr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ysyx_23060240_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_raddr(ifu_raddr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: at most one pending transaction, described by its fields and whether memory took it.
  bit          m_busy;
  bit          m_sent;
  bit          m_own_lsu;
  bit          m_last_lsu;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [7:0]  m_wmask;
  bit          grants[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    check("rst_ifu_req_ready", ifu_req_ready, 0);
    check("rst_lsu_req_ready", lsu_req_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_ifu_resp_valid", ifu_resp_valid, 0);
    check("rst_lsu_resp_valid", lsu_resp_valid, 0);
    check("rst_ifu_rdata", ifu_rdata, 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    m_busy = 0; m_sent = 0; m_own_lsu = 1; m_last_lsu = 1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model.
  task automatic step(input bit iv, input logic [31:0] ia, input bit lv, input bit lwe,
                      input logic [31:0] la, input logic [31:0] ld, input logic [7:0] lm,
                      input bit mrdy, input bit mresp, input logic [31:0] mrd);
    bit win_lsu, acc, dlv;
    ifu_req_valid = iv; ifu_raddr = ia;
    lsu_req_valid = lv; lsu_we = lwe; lsu_addr = la; lsu_wdata = ld; lsu_wmask = lm;
    mem_req_ready = mrdy; mem_resp_valid = mresp; mem_rdata = mrd;
    @(negedge clk);
    if (iv && lv) win_lsu = RR_MODE ? !m_last_lsu : 1'b1;
    else          win_lsu = lv;
    acc = !m_busy && (iv || lv);
    dlv = m_busy && m_sent && mresp;
    check("ifu_req_ready", ifu_req_ready, acc && !win_lsu);
    check("lsu_req_ready", lsu_req_ready, acc && win_lsu);
    check("mem_req_valid", mem_req_valid, m_busy && !m_sent);
    if (m_busy && !m_sent) begin
      check("mem_we", mem_we, m_we);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wdata);
      check("mem_wmask", mem_wmask, m_wmask);
    end
    check("ifu_resp_valid", ifu_resp_valid, dlv && !m_own_lsu);
    check("ifu_rdata", ifu_rdata, (dlv && !m_own_lsu) ? mrd : 32'h0);
    check("lsu_resp_valid", lsu_resp_valid, dlv && m_own_lsu);
    check("lsu_rdata", lsu_rdata, (dlv && m_own_lsu) ? mrd : 32'h0);
    if (ifu_req_ready) grants.push_back(1'b0);
    if (lsu_req_ready) grants.push_back(1'b1);
    if (acc) begin
      m_busy = 1; m_sent = 0; m_own_lsu = win_lsu; m_last_lsu = win_lsu;
      m_we    = win_lsu ? lwe : 1'b0;
      m_addr  = win_lsu ? la  : ia;
      m_wdata = win_lsu ? ld  : 32'h0;
      m_wmask = win_lsu ? lm  : 8'h0;
    end else if (m_busy && !m_sent && mrdy) begin
      m_sent = 1;
    end else if (dlv) begin
      m_busy = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_step(input bit mrdy, input bit mresp, input logic [31:0] mrd);
    step(0, '0, 0, 0, '0, '0, '0, mrdy, mresp, mrd);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Lone IFU fetch, fastest round trip
    step(1, 32'h8000_0000, 0, 0, '0, '0, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    check("fetch_resp_pulse_pre", ifu_resp_valid, 0);
    idle_step(0, 1, 32'h0000_0413);
    idle_step(0, 0, '0);

    // LSU store held through three stalled cycles
    step(0, '0, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 0, 0, '0);
    for (int i = 0; i < 3; i++) idle_step(0, 0, '0);
    check("store_mem_we", mem_we, 1);
    check("store_mem_addr", mem_addr, 32'h8000_1000);
    idle_step(1, 0, '0);
    idle_step(0, 0, '0);
    idle_step(0, 1, 32'h1234_5678);

    // Spurious responses in IDLE and in REQ
    idle_step(0, 1, 32'hAAAA_5555);
    step(1, 32'h8000_0040, 0, 0, '0, '0, '0, 0, 0, '0);
    idle_step(0, 1, 32'h5555_AAAA);
    idle_step(1, 1, 32'h0F0F_0F0F);
    idle_step(0, 1, 32'h0000_0013);

    // Continuous contention over four transactions
    do_reset();
    grants.delete();
    for (int i = 0; i < 12; i++)
      step(1, 32'h8000_0100 + 32'(i), 1, 0, 32'h8000_2000 + 32'(i), '0, '0, 1, 1, 32'(i));
    check("tie_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      check($sformatf("tie_grant_%0d", i), grants[i], RR_MODE ? (i % 2 == 1) : 1'b1);

    // Reset while waiting for a response, then a late response
    idle_step(0, 0, '0);
    step(1, 32'h8000_0200, 0, 0, '0, '0, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    do_reset();
    idle_step(0, 1, 32'hBAD0_BAD0);
    check("late_resp_ifu", ifu_resp_valid, 0);
    step(1, 32'h8000_0204, 0, 0, '0, '0, '0, 0, 0, '0);
    idle_step(1, 0, '0);
    idle_step(0, 1, 32'h0000_0297);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom, $urandom, 8'($urandom), $urandom_range(0, 1),
                $urandom_range(0, 9) < 4, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
